// File: rtl/mod_inverse_eea_if.sv
// ============================================================================
//  Module      : mod_inverse_eea_if
//  Description : Start/done handshake and operand/result bundle for the
//                modular-inverse generator. The master drives the request,
//                the slave (the generator) returns status and result.
//                The cycles field exists only with MODINV_CYCLE_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_inverse_eea_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] phi;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] d;
`ifdef MODINV_CYCLE_COUNT_EN
    logic [15:0]      cycles;

    modport master (output start, e, phi, input busy, done, valid, d, cycles);
    modport slave  (input start, e, phi, output busy, done, valid, d, cycles);
`else
    modport master (output start, e, phi, input busy, done, valid, d);
    modport slave  (input start, e, phi, output busy, done, valid, d);
`endif
endinterface

`default_nettype wire

// File: rtl/mod_inverse_eea.sv
// ============================================================================
//  Module      : mod_inverse_eea
//  Description : d = e^-1 mod phi via the extended Euclidean algorithm with a
//                bit-serial restoring divider (one quotient bit per cycle).
//                Optional macro MODINV_CYCLE_COUNT_EN adds a saturating
//                16-bit busy-cycle counter on the interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_inverse_eea #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mod_inverse_eea_if.slave  bus
);
    localparam int SW = 2 * WIDTH + 2;
    localparam int KW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_REDUCE = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_FIX    = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    logic [2:0]       r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_phi, r_r0, r_r1, r_rem, r_d;
    logic [WIDTH+1:0] r_t0, r_t1, r_tacc;
    logic             r_busy, r_done, r_valid;

    logic [WIDTH-1:0] w_divisor;
    logic [SW-1:0]    w_div_sh;
    logic [SW-1:0]    w_t1_sh;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH+1:0] w_tacc_next;
    logic [WIDTH+1:0] w_fix;
    logic             w_unused;

    // One restoring-divide step: the same datapath serves the initial e mod phi
    // reduction (divisor phi) and each Euclid quotient (divisor r1).
    assign w_divisor   = (r_state == S_REDUCE) ? r_phi : r_r1;
    assign w_div_sh    = {{(WIDTH+2){1'b0}}, w_divisor} << r_k;
    assign w_t1_sh     = {{WIDTH{r_t1[WIDTH+1]}}, r_t1} << r_k;
    assign w_fits      = (w_div_sh <= {{(WIDTH+2){1'b0}}, r_rem});
    assign w_rem_next  = w_fits ? (r_rem - w_div_sh[WIDTH-1:0]) : r_rem;
    assign w_tacc_next = w_fits ? (r_tacc - w_t1_sh[WIDTH+1:0]) : r_tacc;
    // Negative Bezout coefficient is folded into [0, phi) by one add.
    assign w_fix       = r_t0 + (r_t0[WIDTH+1] ? {2'b00, r_phi} : '0);
    // Upper bits are discarded: final values always fit the narrower field.
    assign w_unused    = ^{w_t1_sh[SW-1:WIDTH+2], w_fix[WIDTH+1:WIDTH]};

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.valid = r_valid;
    assign bus.d     = r_d;

    // Control FSM and the Euclid datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_phi   <= '0;
            r_r0    <= '0;
            r_r1    <= '0;
            r_rem   <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_tacc  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_d     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_valid <= 1'b0;
                        r_d     <= '0;
                        r_phi   <= bus.phi;
                        r_rem   <= bus.e;
                    end
                end
                S_LOAD: begin
                    r_k <= KW'(WIDTH - 1);
                    if (r_phi < WIDTH'(2)) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    r_rem <= w_rem_next;
                    r_k   <= r_k - 1'b1;
                    if (r_k == '0) begin
                        r_r0 <= r_phi;
                        r_r1 <= w_rem_next;
                        r_t0 <= '0;
                        r_t1 <= (WIDTH+2)'(1);
                        if (w_rem_next == '0) begin
                            // e is a multiple of phi: no inverse.
                            r_state <= S_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DIV;
                            r_rem   <= r_phi;
                            r_tacc  <= '0;
                            r_k     <= KW'(WIDTH - 1);
                        end
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_tacc <= w_tacc_next;
                    r_k    <= r_k - 1'b1;
                    if (r_k == '0) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_r0 <= r_r1;
                    r_r1 <= r_rem;
                    r_t0 <= r_t1;
                    r_t1 <= r_tacc;
                    if (r_rem != '0) begin
                        r_state <= S_DIV;
                        r_rem   <= r_r1;
                        r_tacc  <= r_t1;
                        r_k     <= KW'(WIDTH - 1);
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_r0 != WIDTH'(1)) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_d     <= w_fix[WIDTH-1:0];
                    r_valid <= 1'b1;
                    r_state <= S_FINISH;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    // FINISH: hold result until the requester releases start.
                    if (!bus.start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MODINV_CYCLE_COUNT_EN
    logic [15:0] r_cycles;

    // Busy-cycle counter: cleared on acceptance, saturating, held when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_cycles <= '0;
        end else if (r_busy && r_cycles != 16'hFFFF) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign bus.cycles = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_inverse_eea.sv
// ============================================================================
//  Module      : tb_mod_inverse_eea
//  Description : Scoreboard bench for mod_inverse_eea at WIDTH 32, 16 and 8.
//                Drivers push reference results; a monitor pops on done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_inverse_eea;
    typedef struct {
        bit          valid;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] phi;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb32[$];
    exp_t sb16[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    mod_inverse_eea_if #(.WIDTH(32)) if32 ();
    mod_inverse_eea_if #(.WIDTH(16)) if16 ();
    mod_inverse_eea_if #(.WIDTH(8))  if8 ();

    mod_inverse_eea #(.WIDTH(32)) u_dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
    mod_inverse_eea #(.WIDTH(16)) u_dut16 (.clk(clk), .reset_n(reset_n), .bus(if16));
    mod_inverse_eea #(.WIDTH(8))  u_dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));

    // Reference: textbook extended Euclid on wide integers.
    function automatic void ref_model(input logic [31:0] e, input logic [31:0] phi,
                                      output bit v, output logic [31:0] d);
        longint r0, r1, s0, s1, q, tmp, p;
        v = 1'b0;
        d = '0;
        if (phi < 32'd2) return;
        p  = longint'({32'b0, phi});
        r0 = p;
        r1 = longint'({32'b0, e}) % p;
        s0 = 0;
        s1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = s0 - q * s1; s0 = s1; s1 = tmp;
        end
        if (r0 == 1) begin
            v = 1'b1;
            d = 32'(((s0 % p) + p) % p);
        end
    endfunction

    function automatic int width_of(input int idx);
        return (idx == 0) ? 32 : (idx == 1) ? 16 : 8;
    endfunction

    function automatic logic [31:0] mask(input int idx, input logic [31:0] v);
        return (idx == 0) ? v : (idx == 1) ? {16'b0, v[15:0]} : {24'b0, v[7:0]};
    endfunction

    function automatic bit done_of(input int idx);
        return (idx == 0) ? if32.done : (idx == 1) ? if16.done : if8.done;
    endfunction

    function automatic bit busy_of(input int idx);
        return (idx == 0) ? if32.busy : (idx == 1) ? if16.busy : if8.busy;
    endfunction

    task automatic drive(input int idx, input bit st, input logic [31:0] e, input logic [31:0] phi);
        case (idx)
            0:       begin if32.start = st; if32.e = e;        if32.phi = phi;        end
            1:       begin if16.start = st; if16.e = e[15:0];  if16.phi = phi[15:0];  end
            default: begin if8.start  = st; if8.e  = e[7:0];   if8.phi  = phi[7:0];   end
        endcase
    endtask

    task automatic expect_bit(input string name, input bit got, input bit req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, req);
        end
    endtask

    // Full handshake; inputs are scrambled after acceptance to prove capture.
    task automatic run(input int idx, input logic [31:0] e_in, input logic [31:0] phi_in, input int hold);
        exp_t        x;
        bit          seen;
        int          w;
        w     = width_of(idx);
        x.e   = mask(idx, e_in);
        x.phi = mask(idx, phi_in);
        ref_model(x.e, x.phi, x.valid, x.d);
        if (idx == 0) sb32.push_back(x);
        else if (idx == 1) sb16.push_back(x);
        else sb8.push_back(x);
        @(negedge clk);
        drive(idx, 1'b1, x.e, x.phi);
        @(negedge clk);
        expect_bit("busy_after_accept", busy_of(idx), 1'b1);
        drive(idx, 1'b1, $urandom, $urandom);
        seen = 1'b0;
        for (int i = 0; i < 4 + w + 2 * w * (w + 1); i++) begin
            if (done_of(idx)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        expect_bit("done_within_bound", seen, 1'b1);
        expect_bit("busy_low_in_finish", busy_of(idx), 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            expect_bit("done_held_with_start", done_of(idx), 1'b1);
            expect_bit("no_retrigger_busy", busy_of(idx), 1'b0);
        end
        drive(idx, 1'b0, $urandom, $urandom);
        @(negedge clk);
        expect_bit("done_drop_after_start_low", done_of(idx), 1'b0);
    endtask

    task automatic check_out(input string name, input exp_t x, input bit got_v,
                             input logic [31:0] got_d, input int meas, input int cyc, input int w);
        logic [63:0] prod;
        checks++;
        if (got_v !== x.valid || got_d !== x.d) begin
            errors++;
            $display("FAIL %s e=%0d phi=%0d: got valid=%0b d=%0d expected valid=%0b d=%0d",
                     name, x.e, x.phi, got_v, got_d, x.valid, x.d);
        end
        if (x.valid) begin
            prod = {32'b0, x.e} * {32'b0, got_d};
            checks++;
            if (prod % {32'b0, x.phi} != 64'd1 || got_d >= x.phi) begin
                errors++;
                $display("FAIL %s_inverse_property e=%0d phi=%0d: got d=%0d", name, x.e, x.phi, got_d);
            end
        end
        checks++;
        if (meas > 3 + w + 2 * w * (w + 1)) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles limit %0d", name, meas, 3 + w + 2 * w * (w + 1));
        end
`ifdef MODINV_CYCLE_COUNT_EN
        checks++;
        if (cyc != meas) begin
            errors++;
            $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, meas);
        end
`else
        if (cyc != 0) $display("note: unexpected cycle value %0d", cyc);
`endif
    endtask

    // Monitor: measures busy cycles and pops the scoreboard on each done rise.
    initial begin
        bit pd32, pd16, pd8;
        int n32, n16, n8, c32, c16, c8;
        pd32 = 0; pd16 = 0; pd8 = 0;
        n32 = 0; n16 = 0; n8 = 0;
        forever begin
            @(negedge clk);
`ifdef MODINV_CYCLE_COUNT_EN
            c32 = int'(if32.cycles); c16 = int'(if16.cycles); c8 = int'(if8.cycles);
`else
            c32 = 0; c16 = 0; c8 = 0;
`endif
            if (!reset_n) begin
                pd32 = 0; pd16 = 0; pd8 = 0;
                n32 = 0; n16 = 0; n8 = 0;
            end else begin
                if (if32.busy) n32++;
                if (if16.busy) n16++;
                if (if8.busy)  n8++;
                if (if32.done && !pd32) begin
                    if (sb32.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w32_unexpected_done: got done=1 expected no done");
                    end else check_out("w32", sb32.pop_front(), if32.valid, if32.d, n32, c32, 32);
                    n32 = 0;
                end
                if (if16.done && !pd16) begin
                    if (sb16.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w16_unexpected_done: got done=1 expected no done");
                    end else check_out("w16", sb16.pop_front(), if16.valid, {16'b0, if16.d}, n16, c16, 16);
                    n16 = 0;
                end
                if (if8.done && !pd8) begin
                    if (sb8.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w8_unexpected_done: got done=1 expected no done");
                    end else check_out("w8", sb8.pop_front(), if8.valid, {24'b0, if8.d}, n8, c8, 8);
                    n8 = 0;
                end
                pd32 = if32.done; pd16 = if16.done; pd8 = if8.done;
            end
        end
    end

    initial begin
        logic [31:0] e, phi, dd;
        bit          v;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        drive(2, 1'b0, 0, 0);
        #1;
        expect_bit("reset_busy", if32.busy | if16.busy | if8.busy, 1'b0);
        expect_bit("reset_done", if32.done | if16.done | if8.done, 1'b0);
        expect_bit("reset_valid_d_zero", (if32.valid | if16.valid | if8.valid) || (if32.d != 0) ||
                   (if16.d != 0) || (if8.d != 0), 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run(0, 17, 3120, 3);
        run(0, 3, 40, 0);
        run(0, 6, 40, 0);
        run(0, 3137, 3120, 0);
        run(0, 3120, 3120, 0);
        run(0, 7, 1, 0);
        run(0, 1, 97, 0);
        run(0, 5, 2, 0);
        run(2, 3, 11, 0);
        run(2, 255, 254, 0);
        run(2, 7, 0, 0);

        // Abort a long computation with an asynchronous reset.
        @(negedge clk);
        drive(0, 1'b1, 65537, 3120000);
        repeat (60) @(negedge clk);
        expect_bit("busy_before_abort", if32.busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        expect_bit("abort_busy_cleared", if32.busy, 1'b0);
        expect_bit("abort_done_low", if32.done, 1'b0);
        expect_bit("abort_valid_d_zero", if32.valid || (if32.d != 0), 1'b0);
        drive(0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_bit("no_done_after_abort", if32.done, 1'b0);
        run(0, 17, 3120, 0);

        // Randomised coprime pairs.
        for (int i = 0; i < 30; i++) begin
            for (int t = 0; t < 50; t++) begin
                phi = 32'($urandom_range(2, 65535));
                e   = {16'b0, 16'($urandom)};
                ref_model(e, phi, v, dd);
                if (v) break;
            end
            run(1, e, phi, 0);
        end
        for (int i = 0; i < 6; i++) begin
            for (int t = 0; t < 50; t++) begin
                phi = $urandom | 32'd2;
                e   = $urandom;
                ref_model(e, phi, v, dd);
                if (v) break;
            end
            run(0, e, phi, 0);
        end
        for (int i = 0; i < 10; i++) run(2, $urandom, $urandom, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb32.size() + sb16.size() + sb8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d pending expected 0",
                     sb32.size() + sb16.size() + sb8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mod_inverse_eea.md
Name: mod_inverse_eea

Overview:
Parametrised modular-inverse generator. It computes d = e^-1 mod phi for RSA key generation using the extended Euclidean algorithm, with an iterative shift-subtract divider, so runtime is O(WIDTH^2) cycles rather than O(phi) trials.
It reports whether an inverse exists (gcd(e,phi)=1).
It sits beside the key-generation controller and uses the same level start/done four-phase handshake as the existing key-gen blocks.

Parameters:
WIDTH, 32, bit width of e, phi, d (>=4)

Ports:
clk  input  1  clock
reset_n  input  1  async active-low reset
start  input  1  level request; sampled in IDLE
e  input  WIDTH  public exponent (any value; reduced mod phi internally)
phi  input  WIDTH  modulus (totient)
busy  output  1  high from accepted start until done rises
done  output  1  high in FINISH; held until start deasserts
valid  output  1  1 = inverse exists, d meaningful; 0 = no inverse
d  output  WIDTH  inverse in [1, phi-1] when valid, else 0

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Reset forces state IDLE, busy=0, done=0, valid=0, d=0. Reset mid-operation aborts the computation; no done pulse follows.
- e and phi are captured at start acceptance. Later input changes are ignored until the next run.
- Internal registers:
  - r0, r1, rem: WIDTH bits unsigned.
  - t0, t1, tacc: WIDTH+2 bits signed.
  - Shifted terms (r1<<k, t1<<k) are formed at 2*WIDTH+2 bits before compare/subtract.
- States:
  - IDLE: if start=1, go to LOAD and set busy=1.
  - LOAD: if phi<2, go to FINISH with valid=0, d=0. Otherwise rem=e, divisor=phi, k=WIDTH-1, go to REDUCE.
  - REDUCE: one restoring-divide step per cycle: if (divisor<<k) <= rem then rem -= divisor<<k. At k=0, set r0=phi, r1=rem, t0=0, t1=1.
    - If r1==0, go to FINISH with valid=0.
    - Else go to DIV with rem=r0, tacc=t0, k=WIDTH-1.
  - DIV: per cycle: if (r1<<k) <= rem then rem -= r1<<k and tacc -= t1<<k. Decrement k. After k=0, go to UPDATE. Each pass is exactly WIDTH cycles.
  - UPDATE (1 cycle): r0<=r1, r1<=rem, t0<=t1, t1<=tacc.
    - If the new r1 != 0, go to DIV (rem=new r0, tacc=new t0).
    - Else go to CHECK.
  - CHECK: if r0 != 1 (gcd>1), go to FINISH with valid=0, d=0. Else go to FIX.
  - FIX: d = (t0<0) ? t0+phi : t0, truncated to WIDTH bits. Set valid=1 and go to FINISH.
  - FINISH: done=1, busy=0. When start=0, go to IDLE with done=0. d and valid are held until the next accepted start, which clears done, valid and d.
- Edge cases:
  - start held high across FINISH does not retrigger.
  - phi=2 with odd e gives d=1.
  - e=1 gives d=1.
  - e==phi behaves as e mod phi = 0, so valid=0.
- Latency: start to done is at most 3 + WIDTH + (2*WIDTH)*(WIDTH+1) cycles. The exact count is data dependent, but deterministic for given e and phi.

Optional Feature:
MODINV_CYCLE_COUNT_EN:
- Defined: adds output cycles [15:0]. It clears on start acceptance, increments each cycle while busy, saturates at 16'hFFFF, and holds in FINISH/IDLE. Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=32, e=17, phi=3120, start held -> done=1, valid=1, d=2753; busy low in FINISH; done drops one cycle after start falls.
2. e=3, phi=40 -> d=27, valid=1. Then e=6, phi=40 -> valid=0, d=0 (gcd=2).
3. e=3137, phi=3120 (e>phi) -> d=2753. Then e=3120, phi=3120 -> valid=0. Then e=7, phi=1 -> valid=0 within 3 cycles.
4. WIDTH=8 instance, e=3, phi=11 -> d=4. Then e=255, phi=254 -> d=1.
5. Start e=65537, phi=3120000 (or any long run); assert reset_n low mid-DIV -> outputs return to reset values asynchronously and no done appears. Rerun e=17, phi=3120 -> 2753.
6. Randomised coprime pairs with WIDTH=16 -> (e*d) mod phi == 1 and d<phi. With MODINV_CYCLE_COUNT_EN defined, cycles equals the measured start-to-done count and is within the latency bound.
